fp_norm_pipe: RTL and testbench

Pipelined, parametrised floating-point normaliser for the FC datapath accumulator output. It takes an unnormalised magnitude/exponent/sign triple from the adder and applies leading-zero detection, left shift and selectable rounding. It handles round carry, overflow, underflow and zero, then packs an IEEE-style word. Three register stages with valid/ready back-pressure give one result per cycle.

---
 rtl/fp_norm_pipe.sv | 151 +++++++++++++++
 tb/tb_fp_norm_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - three-stage floating-point normaliser: LZD, shift/round, exception/pack
module fp_norm_pipe #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic [MANTISSA+4:0]          in_mant,
    input  logic [EXPONENT-1:0]          in_exp,
    input  logic [1:0]                   in_rnd_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXPONENT+MANTISSA:0]   sum_o,
    output logic [2:0]                   out_flags
);
    localparam int W   = MANTISSA + 5;
    localparam int NZW = $clog2(W);
    localparam int EW  = EXPONENT + 2;

    logic en1, en2, en3;
    logic v1, v2, v3;

    assign en3       = !v3 | out_ready;
    assign en2       = !v2 | en3;
    assign en1       = !v1 | en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    // Stage 1: leading-zero detection
    logic [NZW-1:0] nz_c;
    logic           found;

    always_comb begin
        nz_c  = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && in_mant[i]) begin
                nz_c  = NZW'(W - 1 - i);
                found = 1'b1;
            end
        end
    end

    logic                s1_sign, s1_zero;
    logic [W-1:0]        s1_mant;
    logic [EXPONENT-1:0] s1_exp;
    logic [NZW-1:0]      s1_nz;
    logic [1:0]          s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
            s1_nz   <= '0;
            s1_mode <= '0;
        end else if (en1) begin
            v1      <= in_valid;
            s1_sign <= in_sign;
            s1_zero <= (in_mant == '0);
            s1_mant <= in_mant;
            s1_exp  <= in_exp;
            s1_nz   <= nz_c;
            s1_mode <= in_rnd_mode;
        end
    end

    // Stage 2: normalise, the leading one (bit W-1) is implicit so it is dropped here
    logic [W-2:0]        n_c;
    logic [MANTISSA-1:0] frac_c;
    logic                g_c, st_c, l_c, inc_c;
    logic [MANTISSA:0]   frac_r_c;
    logic [EW-1:0]       e_c;

    always_comb begin
        n_c    = (W-1)'(s1_mant << s1_nz);
        frac_c = n_c[W-2:4];
        g_c    = n_c[3];
        st_c   = |n_c[2:0];
        l_c    = n_c[4];
        case (s1_mode)
            2'd0:    inc_c = g_c;
            2'd1:    inc_c = g_c & (st_c | l_c);
            default: inc_c = 1'b0;
        endcase
        frac_r_c = {1'b0, frac_c} + {{MANTISSA{1'b0}}, inc_c};
        e_c      = {2'b00, s1_exp} + EW'(2) - EW'(s1_nz) + EW'(frac_r_c[MANTISSA]);
    end

    logic                s2_sign, s2_zero;
    logic [EW-1:0]       s2_e;
    logic [MANTISSA-1:0] s2_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_e    <= '0;
            s2_frac <= '0;
        end else if (en2) begin
            v2      <= v1;
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_e    <= e_c;
            s2_frac <= frac_r_c[MANTISSA-1:0];
        end
    end

    // Stage 3: exceptions in priority order zero > overflow > underflow
    logic                        ovf_c, unf_c;
    logic [EXPONENT+MANTISSA:0]  sum_c;
    logic [2:0]                  flags_c;

    always_comb begin
        ovf_c   = $signed(s2_e) >= $signed({2'b00, {EXPONENT{1'b1}}});
        unf_c   = s2_e[EW-1] || (s2_e == '0);
        sum_c   = {s2_sign, {EXPONENT{1'b0}}, {MANTISSA{1'b0}}};
        flags_c = 3'b000;
        if (s2_zero) begin
            flags_c = 3'b001;
        end else if (ovf_c) begin
            sum_c   = {s2_sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
            flags_c = 3'b100;
        end else if (unf_c) begin
            flags_c = 3'b010;
        end else begin
            sum_c = {s2_sign, s2_e[EXPONENT-1:0], s2_frac};
        end
    end

    // Output registers only take real results so they stay meaningful while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3        <= 1'b0;
            sum_o     <= '0;
            out_flags <= '0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                sum_o     <= sum_c;
                out_flags <= flags_c;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - randomized self-checking bench for fp_norm_pipe
module tb_fp_norm_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [27:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic [1:0]  in_rnd_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum_o;
    logic [2:0]  out_flags;

    int total = 0;
    int bad = 0;
    logic [34:0] exp_q[$];
    logic [34:0] cur_exp = '0;
    logic        mon_en = 1'b0;
    logic        rand_ready = 1'b0;

    fp_norm_pipe #(.EXPONENT(8), .MANTISSA(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mant(in_mant), .in_exp(in_exp), .in_rnd_mode(in_rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_o(sum_o), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: value-level rounding on the remainder below the kept fraction
    function automatic logic [34:0] ref_model(input logic s, input logic [27:0] m,
                                              input logic [7:0] e, input logic [1:0] md);
        int p, nz, frac, rem, inc, ex;
        logic [27:0] n;
        if (m == 0) return {s, 31'd0, 3'b001};
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        nz   = 27 - p;
        n    = m << nz;
        frac = int'(n >> 4) & 32'h7FFFFF;
        rem  = int'(n & 28'hF);
        case (md)
            2'd0:    inc = (rem >= 8) ? 1 : 0;
            2'd1:    inc = (rem > 8 || (rem == 8 && (frac % 2) == 1)) ? 1 : 0;
            default: inc = 0;
        endcase
        frac = frac + inc;
        ex   = int'(e) + 2 - nz;
        if (frac >= (1 << 23)) begin
            frac = 0;
            ex   = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'd0, 3'b100};
        if (ex <= 0)   return {s, 31'd0, 3'b010};
        return {s, ex[7:0], frac[22:0], 3'b000};
    endfunction

    // Sampled at negedge: inputs are stable and reflect what the next rising edge sees
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("in_ready", in_ready, (exp_q.size() < 3) || out_ready);
            if (exp_q.size() == 0) chk("no_spurious_valid", out_valid, 0);
            if (out_valid && exp_q.size() > 0) begin
                chk("sum", sum_o, exp_q[0][34:3]);
                chk("flags", out_flags, exp_q[0][2:0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic send(input logic s, input logic [27:0] m, input logic [7:0] e,
                        input logic [1:0] md, input logic [34:0] ex);
        int n;
        logic acc;
        in_sign = s; in_mant = m; in_exp = e; in_rnd_mode = md;
        cur_exp = ex;
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic send_rand();
        logic s;
        logic [27:0] m;
        logic [7:0] e;
        logic [1:0] md;
        s  = 1'($urandom_range(0, 1));
        m  = 28'($urandom) >> $urandom_range(0, 28);
        e  = 8'($urandom_range(0, 255));
        md = 2'($urandom_range(0, 3));
        send(s, m, e, md, ref_model(s, m, e, md));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        #1;
    endtask

    logic [27:0] d_mant[12] = '{28'h2000000, 28'h2000002, 28'h2000002, 28'h2000002,
                                28'h2000006, 28'h3FFFFFE, 28'h3FFFFFE, 28'h3FFFFFE,
                                28'h8000000, 28'h2000000, 28'h2000000, 28'h0};
    logic [7:0]  d_exp[12]  = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127,
                                8'd127, 8'd127, 8'd253, 8'd0, 8'd1, 8'd0};
    logic [1:0]  d_mode[12] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2,
                                2'd0, 2'd0, 2'd0, 2'd0};
    logic        d_sign[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [34:0] d_want[12] = '{{32'h3F800000, 3'b000}, {32'h3F800001, 3'b000},
                                {32'h3F800000, 3'b000}, {32'h3F800000, 3'b000},
                                {32'h3F800002, 3'b000}, {32'h40000000, 3'b000},
                                {32'h40000000, 3'b000}, {32'h3FFFFFFF, 3'b000},
                                {32'h7F800000, 3'b100}, {32'h00000000, 3'b010},
                                {32'h00800000, 3'b000}, {32'h80000000, 3'b001}};

    initial begin
        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_sum", sum_o, 0);
        chk("reset_flags", out_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: accept at edge k, out_valid visible after edge k+2
        send(0, 28'h2000000, 8'd127, 2'd0, {32'h3F800000, 3'b000});
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("latency_k1", out_valid, 0);
        @(negedge clk);
        chk("latency_k2", out_valid, 1);
        drain();

        for (int i = 0; i < 12; i++) begin
            send(d_sign[i], d_mant[i], d_exp[i], d_mode[i], d_want[i]);
            in_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        drain();

        // Back-pressure fills the pipe
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_rand();
        for (int i = 0; i < 300; i++) send_rand();
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset mid-stream with a full pipe
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", sum_o, 0);
        chk("midrst_flags", out_flags, 0);
        in_valid = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send_rand();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        chk("global_timeout", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
